// File: rtl/vec_scale_mult_4x1_pkg.sv
// zf_fx_pkg: shared fixed-point definitions for the ZF 2x2 MIMO datapath.
//   W_DEF / FRAC_DEF / N_DEF : default element width, fractional bits, vector length
//   SAT_MAX / SAT_MIN        : saturation bounds for a W_DEF-bit signed element
//   state_t                  : sequencing states shared by the vector blocks
package zf_fx_pkg;

  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;
  localparam int N_DEF    = 4;

  localparam logic signed [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic signed [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vec_scale_mult_4x1_if.sv
// vec_scale_mult_4x1_if: handshake and data bundle of the vector scaler.
//   enable     : global clock-enable (0 freezes the block)
//   accept_in  : upstream strobe, vec/el valid this cycle
//   accept_out : block idle, will capture on accept_in
//   ready_out  : res valid, one-cycle pulse
//   vec / el   : N-element input vector (element 0 in the MSB slice) and scalar
//   res        : scaled vector, same slice order as vec
// master = producer/consumer side, slave = the scaler.
interface vec_scale_mult_4x1_if
  import zf_fx_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
);

  logic           enable;
  logic           accept_in;
  logic           accept_out;
  logic           ready_out;
  logic [N*W-1:0] vec;
  logic [W-1:0]   el;
  logic [N*W-1:0] res;

  modport master (
    output enable, accept_in, vec, el,
    input  accept_out, ready_out, res
  );

  modport slave (
    input  enable, accept_in, vec, el,
    output accept_out, ready_out, res
  );

endinterface

// File: rtl/vec_scale_mult_4x1_mul.sv
// fx_mul_sat: combinational signed fixed-point multiply with saturation.
//   a, b : W-bit signed operands with FRAC fractional bits
//   y    : (a*b) >>> FRAC, clamped to [-2^(W-1), 2^(W-1)-1]
// Build option MULT_ROUND_EN: add 2^(FRAC-1) before the shift (round half up);
// otherwise the arithmetic shift truncates towards minus infinity.
module fx_mul_sat
  import zf_fx_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  // One guard bit above the full 2W product keeps the rounding add overflow-free.
  localparam int PW = 2*W + 1;

  localparam logic signed [PW-1:0] HI = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] LO = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] adj;
  logic signed [PW-1:0] shifted;

`ifdef MULT_ROUND_EN
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC-1);
`endif

  always_comb begin
    a_ext = {{(W+1){a[W-1]}}, a};
    b_ext = {{(W+1){b[W-1]}}, b};
    prod  = a_ext * b_ext;
`ifdef MULT_ROUND_EN
    adj   = prod + RND;
`else
    adj   = prod;
`endif
    shifted = adj >>> FRAC;
    if (shifted > HI) begin
      y = HI[W-1:0];
    end else if (shifted < LO) begin
      y = LO[W-1:0];
    end else begin
      y = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/vec_scale_mult_4x1.sv
// vec_scale_mult_4x1: scales an N-element fixed-point vector by one scalar,
// res[i] = sat((vec[i] * el) >>> FRAC), using one shared multiplier stepped
// over the elements. Multiplicative counterpart of the 4-over-1 vector divider.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : enable, accept_in, accept_out, ready_out, vec, el, res
// Build option MULT_ROUND_EN (in fx_mul_sat) selects round-half-up instead of
// truncation; latency and handshake are unchanged.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | accept_out=1, waits for accept_in, latches vec/el
// ST_MUL  | one element per enabled edge into staging, idx counts 0..N-1
// ST_DONE | res updated, ready_out=1 until the next enabled edge
module vec_scale_mult_4x1
  import zf_fx_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int N    = N_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vec_scale_mult_4x1_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N-1);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [N*W-1:0]        vec_q, vec_d;
  logic signed [W-1:0]   el_q, el_d;
  logic [N*W-1:0]        stage_q, stage_d;
  logic [N*W-1:0]        res_q, res_d;
  logic                  acc_q, acc_d;
  logic                  rdy_q, rdy_d;

  int                    slot;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_y;

  // Element 0 sits in the MSB slice, so idx walks the slices downwards.
  assign slot  = N - 1 - int'(idx_q);
  assign mul_a = vec_q[slot*W +: W];

  fx_mul_sat #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mul (
    .a (mul_a),
    .b (el_q),
    .y (mul_y)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    el_d    = el_q;
    stage_d = stage_q;
    res_d   = res_q;
    acc_d   = acc_q;
    rdy_d   = rdy_q;

    if (bus.enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.accept_in) begin
            vec_d   = bus.vec;
            el_d    = bus.el;
            idx_d   = '0;
            acc_d   = 1'b0;
            state_d = ST_MUL;
          end
        end
        ST_MUL: begin
          stage_d[slot*W +: W] = mul_y;
          idx_d                = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            // The last product goes straight into res with the staged ones.
            res_d   = stage_d;
            idx_d   = '0;
            rdy_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          rdy_d   = 1'b0;
          acc_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          rdy_d   = 1'b0;
          acc_d   = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      el_q    <= '0;
      stage_q <= '0;
      res_q   <= '0;
      acc_q   <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      el_q    <= el_d;
      stage_q <= stage_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.accept_out = acc_q;
  assign bus.ready_out  = rdy_q;
  assign bus.res        = res_q;

endmodule

// File: tb/tb_vec_scale_mult_4x1.sv
module tb_vec_scale_mult_4x1;

  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int N    = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  vec_scale_mult_4x1_if #(.W(W), .N(N)) bus ();

  vec_scale_mult_4x1 #(.W(W), .FRAC(FRAC), .N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: exact integer product, floor division, clamp.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p, q, d;
    d = longint'(1) << FRAC;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef MULT_ROUND_EN
    p = p + d / 2;
`endif
    q = p / d;
    if ((p % d != 0) && (p < 0)) q = q - 1;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return q[W-1:0];
  endfunction

  function automatic logic [N*W-1:0] ref_vec(input logic [N*W-1:0] v, input logic [W-1:0] e);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*W +: W] = ref_mul(v[(N-1-i)*W +: W], e);
    return r;
  endfunction

  // Transaction-level model: count enabled edges since the accepting edge.
  // 0 = idle, 1..N = computing, N+1 = result presented.
  int             m_cnt = 0;
  logic [N*W-1:0] m_job = '0;
  logic [N*W-1:0] m_res = '0;
  bit             chk_en = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_cnt = 0;
      m_res = '0;
    end else if (bus.enable) begin
      if (m_cnt == 0) begin
        if (bus.accept_in) begin
          m_job = ref_vec(bus.vec, bus.el);
          m_cnt = 1;
        end
      end else if (m_cnt < N) begin
        m_cnt++;
      end else if (m_cnt == N) begin
        m_res = m_job;
        m_cnt = N + 1;
      end else begin
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_accept_out", 64'(bus.accept_out), 64'(m_cnt == 0));
      check("cyc_ready_out",  64'(bus.ready_out),  64'(m_cnt == N + 1));
      check("cyc_res",        64'(bus.res),        64'(m_res));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!bus.accept_out && k < 20) begin tick(); k++; end
    if (!bus.accept_out) check("accept_out_timeout", 64'(bus.accept_out), 64'(1));
  endtask

  task automatic wait_ready(inout int lat);
    while (!bus.ready_out && lat < 40) begin tick(); lat++; end
    if (!bus.ready_out) check("ready_out_timeout", 64'(bus.ready_out), 64'(1));
  endtask

  task automatic run_job(input logic [N*W-1:0] v, input logic [W-1:0] e,
                         output logic [N*W-1:0] r, output int lat);
    wait_idle();
    bus.vec = v; bus.el = e; bus.accept_in = 1'b1;
    tick();
    bus.accept_in = 1'b0;
    lat = 1;
    wait_ready(lat);
    r = bus.res;
  endtask

  function automatic logic [W-1:0] rand_elem();
    case ($urandom_range(7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  localparam logic [N*W-1:0] V1 = 64'h0100_0080_FF00_7FFF;
  localparam logic [N*W-1:0] R1 = 64'h0200_0100_FE00_7FFF;
  localparam logic [N*W-1:0] V2 = 64'h8000_0001_FFFF_0000;
  localparam logic [N*W-1:0] R2 = 64'h8000_0002_FFFE_0000;
  localparam logic [N*W-1:0] V3 = 64'h0001_FFFF_0000_0000;
`ifdef MULT_ROUND_EN
  localparam logic [N*W-1:0] R3 = 64'h0001_0000_0000_0000;
`else
  localparam logic [N*W-1:0] R3 = 64'h0000_FFFF_0000_0000;
`endif

  initial begin
    logic [N*W-1:0] r;
    logic [N*W-1:0] held;
    int lat;
    int pulses;

    reset_n = 1'b0;
    bus.enable = 1'b1; bus.accept_in = 1'b0; bus.vec = '0; bus.el = '0;
    repeat (3) tick();
    check("reset_accept_out", 64'(bus.accept_out), 64'(1));
    check("reset_ready_out",  64'(bus.ready_out),  64'(0));
    check("reset_res",        64'(bus.res),        64'(0));

    // Model pinned to hand-computed values.
    check("model_t1", 64'(ref_vec(V1, 16'h0200)), 64'(R1));
    check("model_t2", 64'(ref_vec(V2, 16'h0200)), 64'(R2));
    check("model_t3", 64'(ref_vec(V3, 16'h0080)), 64'(R3));
    check("model_sat_pos", 64'(ref_mul(16'h8000, 16'h8000)), 64'(16'h7FFF));

    reset_n = 1'b1;
    tick();
    chk_en = 1'b1;

    run_job(V1, 16'h0200, r, lat);
    check("t1_res", 64'(r), 64'(R1));
    check("t1_latency", 64'(lat), 64'(5));

    run_job(V2, 16'h0200, r, lat);
    check("t2_res", 64'(r), 64'(R2));

    run_job(V3, 16'h0080, r, lat);
    check("t3_res", 64'(r), 64'(R3));

    // accept_in held high: second vector ignored until the next idle cycle.
    wait_idle();
    bus.vec = V1; bus.el = 16'h0200; bus.accept_in = 1'b1;
    tick();
    bus.vec = V2;
    lat = 1;
    wait_ready(lat);
    check("t4_first_res", 64'(bus.res), 64'(R1));
    check("t4_first_latency", 64'(lat), 64'(5));
    tick();
    check("t4_idle_after_done", 64'(bus.accept_out), 64'(1));
    tick();
    bus.accept_in = 1'b0;
    lat = 1;
    wait_ready(lat);
    check("t4_second_res", 64'(bus.res), 64'(R2));
    check("t4_second_latency", 64'(lat), 64'(5));

    // enable low for 3 cycles mid-MUL.
    wait_idle();
    bus.vec = V1; bus.el = 16'h0200; bus.accept_in = 1'b1;
    tick();
    bus.accept_in = 1'b0;
    lat = 1;
    tick(); lat++;
    bus.enable = 1'b0;
    repeat (3) begin tick(); lat++; end
    bus.enable = 1'b1;
    wait_ready(lat);
    check("t5_res", 64'(bus.res), 64'(R1));
    check("t5_latency", 64'(lat), 64'(8));
    // pending ready_out stretches while enable is low
    held = bus.res;
    bus.enable = 1'b0;
    repeat (2) tick();
    check("t5_ready_held", 64'(bus.ready_out), 64'(1));
    check("t5_res_held", 64'(bus.res), 64'(held));
    bus.enable = 1'b1;
    tick();
    check("t5_ready_drop", 64'(bus.ready_out), 64'(0));

    // reset mid-operation at idx=2.
    wait_idle();
    bus.vec = V2; bus.el = 16'h0200; bus.accept_in = 1'b1;
    tick();
    bus.accept_in = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("t6_accept_out", 64'(bus.accept_out), 64'(1));
    check("t6_res_zero", 64'(bus.res), 64'(0));
    check("t6_ready_low", 64'(bus.ready_out), 64'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    pulses = 0;
    repeat (10) begin tick(); if (bus.ready_out) pulses++; end
    check("t6_no_ready_pulse", 64'(pulses), 64'(0));

    // Randomised traffic, checked every cycle against the model.
    repeat (600) begin
      bus.enable    = ($urandom_range(9) != 0);
      bus.accept_in = $urandom_range(1);
      for (int i = 0; i < N; i++) bus.vec[i*W +: W] = rand_elem();
      bus.el = rand_elem();
      tick();
    end
    bus.enable = 1'b1;
    bus.accept_in = 1'b0;
    repeat (8) tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
